// File: rtl/mem_access_stage.sv
// Memory-access stage: req/ack handshake with data memory, upstream stall,
// registered write-back bundle, sticky timeout/alignment error flags.
//
// Ports:
//   clock, reset (async, active-low)
//   in_valid, alu_result, store_data, dest_reg, mem_read, mem_write : from EX
//   stall      : comb, hold upstream register
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack : data memory
//   wb_data, wb_reg, wb_valid : registered write-back bundle
//   err_timeout, err_align    : sticky error flags
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_valid,
  output logic        err_timeout,
  output logic        err_align
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [4:0]  ld_reg_q, ld_reg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic        wb_valid_q, wb_valid_d;
  logic        err_to_q, err_to_d;
  logic        err_al_q, err_al_d;

  logic mem_op;
  logic aligned;
  logic timeout_hit;

  assign mem_op  = mem_read | mem_write;
  assign aligned = (alu_result[1:0] == 2'b00);

  // Zero disables the timeout entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (cnt_q == TO_LAST);

  assign stall =
    ((state_q == S_IDLE) & in_valid & mem_op & aligned) |
    ((state_q == S_WAIT) & ~mem_ack & ~timeout_hit);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_reg_d    = ld_reg_q;
    wb_data_d   = wb_data_q;
    wb_reg_d    = wb_reg_q;
    wb_valid_d  = 1'b0;
    err_to_d    = err_to_q;
    err_al_d    = err_al_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!mem_op) begin
            wb_data_d  = alu_result;
            wb_reg_d   = dest_reg;
            wb_valid_d = 1'b1;
          end else if (!aligned) begin
            err_al_d = 1'b1;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = mem_write;
            mem_addr_d  = {alu_result[31:2], 2'b00};
            mem_wdata_d = store_data;
            ld_reg_d    = dest_reg;
            cnt_d       = '0;
            state_d     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Ack beats a coincident timeout.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_IDLE;
          if (!mem_we_q) begin
            wb_data_d  = mem_rdata;
            wb_reg_d   = ld_reg_q;
            wb_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          err_to_d  = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_reg_q    <= '0;
      wb_data_q   <= '0;
      wb_reg_q    <= '0;
      wb_valid_q  <= 1'b0;
      err_to_q    <= 1'b0;
      err_al_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_reg_q    <= ld_reg_d;
      wb_data_q   <= wb_data_d;
      wb_reg_q    <= wb_reg_d;
      wb_valid_q  <= wb_valid_d;
      err_to_q    <= err_to_d;
      err_al_q    <= err_al_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_data     = wb_data_q;
  assign wb_reg      = wb_reg_q;
  assign wb_valid    = wb_valid_q;
  assign err_timeout = err_to_q;
  assign err_align   = err_al_q;

endmodule
